// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, exception codes and FSM encoding for the pipeline controller.
package pipeline_ctrl_pkg;

    localparam logic        STOP       = 1'b1;
    localparam logic        NO_STOP    = 1'b0;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    localparam logic [31:0] EXC_INT          = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
    localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV           = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

    localparam logic [5:0] STALL_NONE  = {6{NO_STOP}};
    localparam logic [5:0] STALL_UP_ID = 6'b000111;
    localparam logic [5:0] STALL_UP_EX = 6'b001111;
    localparam logic [5:0] STALL_UP_MEM = 6'b011111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } ctrl_state_t;

    // ERET returns to the saved EPC; everything else enters the common handler.
    function automatic logic [31:0] decode_new_pc(input logic [31:0] code,
                                                  input logic [31:0] epc,
                                                  input logic [31:0] vector);
        logic [31:0] pc;
        pc = vector;
        case (code)
            EXC_ERET: pc = epc;
            EXC_INT, EXC_SYSCALL, EXC_INST_INVALID, EXC_OV, EXC_TRAP: pc = vector;
            default: pc = vector;
        endcase
        return pc;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Enable/clear counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Merges stage stall requests and turns MEM exceptions into a one-cycle flush,
// deferring the flush while a data-bus transaction is still outstanding.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_if,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             exc_pending,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_state_t state_q, state_d;
    logic [31:0] pend_code_q, pend_code_d;
    logic [31:0] pend_epc_q, pend_epc_d;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q     <= ST_RUN;
            pend_code_q <= ZERO_WORD;
            pend_epc_q  <= ZERO_WORD;
        end else begin
            state_q     <= state_d;
            pend_code_q <= pend_code_d;
            pend_epc_q  <= pend_epc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_code_d = pend_code_q;
        pend_epc_d  = pend_epc_q;
        stall       = STALL_NONE;
        flush       = 1'b0;
        new_pc      = ZERO_WORD;

        if (rst != RST_ENABLE) begin
            case (state_q)
                ST_RUN: begin
                    if (excepttype_i != ZERO_WORD && stallreq_from_mem) begin
                        // Never flush mid-transaction: hold everything and remember the exception.
                        stall       = STALL_UP_MEM;
                        pend_code_d = excepttype_i;
                        pend_epc_d  = cp0_epc_i;
                        state_d     = ST_PEND;
                    end else if (excepttype_i != ZERO_WORD) begin
                        flush  = 1'b1;
                        new_pc = decode_new_pc(excepttype_i, cp0_epc_i, EXC_VECTOR);
                    end else if (stallreq_from_mem) begin
                        stall = STALL_UP_MEM;
                    end else if (stallreq_from_ex) begin
                        stall = STALL_UP_EX;
                    end else if (stallreq_from_id || stallreq_from_if) begin
                        stall = STALL_UP_ID;
                    end
                end
                ST_PEND: begin
                    if (stallreq_from_mem) begin
                        stall = STALL_UP_MEM;
                    end else begin
                        flush       = 1'b1;
                        new_pc      = decode_new_pc(pend_code_q, pend_epc_q, EXC_VECTOR);
                        pend_code_d = ZERO_WORD;
                        pend_epc_d  = ZERO_WORD;
                        state_d     = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign exc_pending = (state_q == ST_PEND) && (rst != RST_ENABLE);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (stall[0] == STOP),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed check of pipeline_ctrl against a rule-level model,
// with a second 4-bit-counter instance for saturation.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        req_if, req_id, req_ex, req_mem;
    logic [31:0] exc_code, epc;

    logic [5:0]  stall, stall4;
    logic        flush, flush4;
    logic [31:0] new_pc, new_pc4;
    logic        exc_pending, exc_pending4;
    logic [31:0] stall_cycles, flush_count;
    logic [3:0]  stall_cycles4, flush_count4;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 0;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .stallreq_from_if(req_if), .stallreq_from_id(req_id),
        .stallreq_from_ex(req_ex), .stallreq_from_mem(req_mem),
        .excepttype_i(exc_code), .cp0_epc_i(epc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .exc_pending(exc_pending),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .stallreq_from_if(req_if), .stallreq_from_id(req_id),
        .stallreq_from_ex(req_ex), .stallreq_from_mem(req_mem),
        .excepttype_i(exc_code), .cp0_epc_i(epc),
        .stall(stall4), .flush(flush4), .new_pc(new_pc4),
        .exc_pending(exc_pending4),
        .stall_cycles(stall_cycles4), .flush_count(flush_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step(input bit r, input bit i_f, input bit i_d, input bit e,
                        input bit m, input logic [31:0] code, input logic [31:0] pc);
        @(posedge clk);
        #1;
        rst = r; req_if = i_f; req_id = i_d; req_ex = e; req_mem = m;
        exc_code = code; epc = pc;
    endtask

    // Rule-level model: one pending flag plus the captured exception.
    bit          m_pend = 0;
    logic [31:0] m_code = 0, m_epc = 0;
    longint      m_sc = 0, m_fc = 0, m_sc4 = 0, m_fc4 = 0;

    function automatic logic [31:0] target(input logic [31:0] code, input logic [31:0] pc);
        return (code == 32'he) ? pc : 32'h20;
    endfunction

    always @(negedge clk) begin
        logic [5:0]  e_stall;
        logic        e_flush;
        logic        e_pend;
        logic [31:0] e_pc;
        if (checking) begin
            e_stall = 6'd0; e_flush = 1'b0; e_pc = 32'd0;
            e_pend  = !rst && m_pend;
            if (!rst) begin
                if (m_pend) begin
                    if (req_mem) e_stall = 6'b011111;
                    else begin e_flush = 1'b1; e_pc = target(m_code, m_epc); end
                end else if (exc_code != 0) begin
                    if (req_mem) e_stall = 6'b011111;
                    else begin e_flush = 1'b1; e_pc = target(exc_code, epc); end
                end else if (req_mem) e_stall = 6'b011111;
                else if (req_ex)      e_stall = 6'b001111;
                else if (req_id || req_if) e_stall = 6'b000111;
            end

            check_value("stall", {26'd0, stall}, {26'd0, e_stall});
            check_value("flush", {31'd0, flush}, {31'd0, e_flush});
            check_value("exc_pending", {31'd0, exc_pending}, {31'd0, e_pend});
            if (e_flush) check_value("new_pc", new_pc, e_pc);
            check_value("stall_cycles", stall_cycles, m_sc[31:0]);
            check_value("flush_count", flush_count, m_fc[31:0]);
            check_value("stall_cycles4", {28'd0, stall_cycles4}, m_sc4[31:0]);
            check_value("flush_count4", {28'd0, flush_count4}, m_fc4[31:0]);

            if (rst) begin
                m_pend = 0; m_code = 0; m_epc = 0;
                m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
            end else begin
                if (m_pend && !req_mem) m_pend = 0;
                else if (!m_pend && exc_code != 0 && req_mem) begin
                    m_pend = 1; m_code = exc_code; m_epc = epc;
                end
                if (e_stall[0]) begin
                    if (m_sc < 64'hFFFF_FFFF) m_sc++;
                    if (m_sc4 < 15) m_sc4++;
                end
                if (e_flush) begin
                    if (m_fc < 64'hFFFF_FFFF) m_fc++;
                    if (m_fc4 < 15) m_fc4++;
                end
            end
        end
    end

    initial begin
        logic [31:0] codes [7];
        codes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h0};
        rst = 1'b1; req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
        exc_code = 0; epc = 0;

        @(posedge clk);
        #1; checking = 1;
        #3;
        check_value("reset stall", {26'd0, stall}, 32'h0);
        check_value("reset flush", {31'd0, flush}, 32'h0);
        check_value("reset new_pc", new_pc, 32'h0);
        check_value("reset exc_pending", {31'd0, exc_pending}, 32'h0);

        step(0, 0, 1, 1, 0, 0, 0);                 #3;
        check_value("prio id+ex", {26'd0, stall}, 32'h0f);
        step(0, 0, 1, 1, 1, 0, 0);                 #3;
        check_value("prio mem", {26'd0, stall}, 32'h1f);
        step(0, 0, 0, 1, 0, 32'h8, 0);             #3;
        check_value("imm flush", {31'd0, flush}, 32'h1);
        check_value("imm stall", {26'd0, stall}, 32'h0);
        check_value("imm new_pc", new_pc, 32'h20);
        step(0, 0, 0, 0, 0, 32'he, 32'h1234);      #3;
        check_value("flush_count after imm", flush_count, 32'h1);
        check_value("stall_cycles after prio", stall_cycles, 32'h2);
        check_value("eret new_pc", new_pc, 32'h1234);
        check_value("eret flush", {31'd0, flush}, 32'h1);
        step(0, 0, 0, 0, 0, 0, 0);                 #3;
        check_value("eret one cycle", {31'd0, flush}, 32'h0);

        step(0, 0, 0, 0, 1, 32'hc, 32'h55);        #3;
        check_value("defer c1 stall", {26'd0, stall}, 32'h1f);
        check_value("defer c1 flush", {31'd0, flush}, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 0, 0, 1, 32'he, 32'h999);   #3;
            check_value("defer pending", {31'd0, exc_pending}, 32'h1);
            check_value("defer stall", {26'd0, stall}, 32'h1f);
            check_value("defer flush", {31'd0, flush}, 32'h0);
        end
        step(0, 0, 0, 0, 0, 0, 0);                 #3;
        check_value("defer release flush", {31'd0, flush}, 32'h1);
        check_value("defer release new_pc", new_pc, 32'h20);

        step(0, 0, 0, 0, 1, 32'hc, 0);
        step(1, 0, 0, 0, 1, 0, 0);                 #3;
        check_value("rst-pend stall", {26'd0, stall}, 32'h0);
        check_value("rst-pend exc_pending", {31'd0, exc_pending}, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0);                 #3;
        check_value("post-rst flush", {31'd0, flush}, 32'h0);
        check_value("post-rst stall_cycles", stall_cycles, 32'h0);
        check_value("post-rst flush_count", flush_count, 32'h0);

        for (int k = 0; k < 20; k++) step(0, 1, 0, 0, 0, 0, 0);
        #3;
        check_value("sat stall_cycles4", {28'd0, stall_cycles4}, 32'hf);
        step(0, 1, 0, 0, 0, 0, 0);                 #3;
        check_value("sat hold stall_cycles4", {28'd0, stall_cycles4}, 32'hf);

        for (int k = 0; k < 3000; k++) begin
            logic [31:0] c;
            c = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 6)] : 32'h0;
            if ($urandom_range(0, 15) == 0) c = $urandom;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, c, $urandom);
        end

        step(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #6;
        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
